vram_arbiter: RTL

- Shares the single-port 32-bit VRAM between three requesters:
  - the host bus-master port (8-bit, strobe-only, no backpressure),
  - the layer-fetch engine,
  - the sprite-fetch engine.
- Host accesses always win and are issued in the same cycle as the strobe. The two fetch engines share the remaining cycles round-robin, with an anti-starvation boost.
- Sits between the external bus interface / renderers and the VRAM macro.

---
 rtl/vram_arb_pkg.sv | 21 ++
 rtl/vram_arb_rr2.sv | 78 +++++++
 rtl/vram_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// Shared encodings and helpers for the VRAM arbiter.
package vram_arb_pkg;

  localparam int unsigned OWN_W = 2;

  // Read-return pipeline owner encoding
  localparam logic [OWN_W-1:0] OWN_NONE = 2'd0;
  localparam logic [OWN_W-1:0] OWN_HOST = 2'd1;
  localparam logic [OWN_W-1:0] OWN_L    = 2'd2;
  localparam logic [OWN_W-1:0] OWN_S    = 2'd3;

  // Fetch port indices inside the round-robin picker
  localparam int unsigned PORT_L = 0;
  localparam int unsigned PORT_S = 1;

  // One-hot byte-lane write enable for a host byte address
  function automatic logic [3:0] lane_mask(input logic [1:0] addr_lo);
    lane_mask = 4'b0001 << addr_lo;
  endfunction

endpackage

// File: rtl/vram_arb_rr2.sv
// Two-input round-robin picker with per-port starvation counters.
module vram_arb_rr2
  import vram_arb_pkg::*;
#(
  parameter int unsigned STARVE = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] reqs,
  input  logic       blocked,
  output logic [1:0] grant_c
);

  logic                  rr_ptr_q, rr_ptr_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            starved_c;
  logic                  other_c;

  // A port is boosted only while it still requests after STARVE lost cycles
  always_comb begin
    starved_c = 2'b00;
    for (int i = 0; i < 2; i++) begin
      starved_c[i] = reqs[i] && (cnt_q[i] == CNT_W'(STARVE));
    end
    other_c = ~rr_ptr_q;
  end

  // Grant selection: starved port first, then round-robin order
  always_comb begin
    grant_c = 2'b00;
    if (!blocked) begin
      if (&starved_c) begin
        grant_c[rr_ptr_q] = 1'b1;
      end else if (starved_c[PORT_L]) begin
        grant_c[PORT_L] = 1'b1;
      end else if (starved_c[PORT_S]) begin
        grant_c[PORT_S] = 1'b1;
      end else if (reqs[rr_ptr_q]) begin
        grant_c[rr_ptr_q] = 1'b1;
      end else if (reqs[other_c]) begin
        grant_c[other_c] = 1'b1;
      end
    end
  end

  // Pointer hands priority to the other port after a fetch grant; counters saturate
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    cnt_d    = '0;
    if (grant_c[PORT_L]) begin
      rr_ptr_d = 1'b1;
    end else if (grant_c[PORT_S]) begin
      rr_ptr_d = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (reqs[i] && !grant_c[i]) begin
        if (cnt_q[i] == CNT_W'(STARVE)) begin
          cnt_d[i] = cnt_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Arbitration state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port 32-bit VRAM between the host port and two fetch engines.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned STARVE = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_strobe,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wrdata,
  output logic [7:0]        host_rddata,
  input  logic              l_req,
  input  logic [ADDR_W-3:0] l_addr,
  output logic              l_ack,
  output logic              l_rvalid,
  input  logic              s_req,
  input  logic [ADDR_W-3:0] s_addr,
  output logic              s_ack,
  output logic              s_rvalid,
  output logic [31:0]       fetch_rddata,
  output logic              mem_en,
  output logic [3:0]        mem_wren,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wrdata,
  input  logic [31:0]       mem_rddata
);

  logic             host_grant_c;
  logic             blocked_c;
  logic [1:0]       fetch_grant_c;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [1:0]       byte_sel_q, byte_sel_d;

  // Nothing is granted while reset is held so every output stays quiet
  always_comb begin
    host_grant_c = host_strobe && !rst;
    blocked_c    = host_strobe || rst;
  end

  vram_arb_rr2 #(
    .STARVE (STARVE),
    .CNT_W  (CNT_W)
  ) u_rr2 (
    .clk     (clk),
    .rst     (rst),
    .reqs    ({s_req, l_req}),
    .blocked (blocked_c),
    .grant_c (fetch_grant_c)
  );

  // Memory-side mux, acks and capture of the read-return owner
  always_comb begin
    mem_en     = 1'b0;
    mem_wren   = 4'b0000;
    mem_addr   = '0;
    mem_wrdata = '0;
    l_ack      = 1'b0;
    s_ack      = 1'b0;
    owner_d    = OWN_NONE;
    byte_sel_d = 2'b00;
    if (host_grant_c) begin
      mem_en   = 1'b1;
      mem_addr = host_addr[ADDR_W-1:2];
      if (host_write) begin
        mem_wren   = lane_mask(host_addr[1:0]);
        mem_wrdata = {4{host_wrdata}};
      end else begin
        owner_d    = OWN_HOST;
        byte_sel_d = host_addr[1:0];
      end
    end else if (fetch_grant_c[PORT_L]) begin
      mem_en   = 1'b1;
      mem_addr = l_addr;
      l_ack    = 1'b1;
      owner_d  = OWN_L;
    end else if (fetch_grant_c[PORT_S]) begin
      mem_en   = 1'b1;
      mem_addr = s_addr;
      s_ack    = 1'b1;
      owner_d  = OWN_S;
    end
  end

  // Read-return pipeline register; reset discards any in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      byte_sel_q <= 2'b00;
    end else begin
      owner_q    <= owner_d;
      byte_sel_q <= byte_sel_d;
    end
  end

  // Steer returning read data to its owner, zero otherwise
  always_comb begin
    host_rddata  = 8'h00;
    fetch_rddata = 32'h0;
    l_rvalid     = 1'b0;
    s_rvalid     = 1'b0;
    case (owner_q)
      OWN_HOST: begin
        case (byte_sel_q)
          2'd0:    host_rddata = mem_rddata[7:0];
          2'd1:    host_rddata = mem_rddata[15:8];
          2'd2:    host_rddata = mem_rddata[23:16];
          default: host_rddata = mem_rddata[31:24];
        endcase
      end
      OWN_L: begin
        fetch_rddata = mem_rddata;
        l_rvalid     = 1'b1;
      end
      OWN_S: begin
        fetch_rddata = mem_rddata;
        s_rvalid     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
